// File: rtl/inst_fetch_pkg.sv
// rtl/inst_fetch_pkg.sv - shared constants for the instruction fetch slice
//
// Bus widths, fetch queue depth, reset polarity, chip-enable encodings and
// the instruction alignment mask used by inst_fetch and fetch_fifo.
package inst_fetch_pkg;

    localparam int INST_ADDR_W      = 32;
    localparam int INST_BUS_W       = 32;
    localparam int FETCH_DEPTH      = 2;
    localparam int FETCH_DEPTH_LOG2 = 1;

    localparam logic RST_ENABLE   = 1'b0;
    localparam logic CHIP_ENABLE  = 1'b1;
    localparam logic CHIP_DISABLE = 1'b0;

    localparam logic [31:0] ZERO_WORD       = 32'h0000_0000;
    localparam logic [31:0] INST_ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - prefetch queue of {pc, inst} pairs for the fetch stage
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   clr_i             drop all entries; wins over push_i and pop_i
//   push_i            write {push_pc_i, push_inst_i} at the tail
//   pop_i             retire the head (caller qualifies with head_valid_o)
//   count_o           number of occupied entries, 0..DEPTH
//   head_valid_o      queue holds at least one entry
//   head_pc_o/inst_o  head entry; when empty, the last head that was shown
module fetch_fifo
    import inst_fetch_pkg::*;
#(
    parameter int ADDR_W = INST_ADDR_W,
    parameter int INST_W = INST_BUS_W,
    parameter int DEPTH  = FETCH_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr_i,
    input  logic                         push_i,
    input  logic [ADDR_W-1:0]            push_pc_i,
    input  logic [INST_W-1:0]            push_inst_i,
    input  logic                         pop_i,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         head_valid_o,
    output logic [ADDR_W-1:0]            head_pc_o,
    output logic [INST_W-1:0]            head_inst_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] mem_pc_q   [DEPTH];
    logic [INST_W-1:0] mem_inst_q [DEPTH];
    logic [PTR_W-1:0]  wr_q, rd_q;
    logic [CNT_W-1:0]  cnt_q;
    // Copy of whatever the head showed last, so decode sees stable values
    // while the queue is empty (including right after a clear).
    logic [ADDR_W-1:0] hold_pc_q;
    logic [INST_W-1:0] hold_inst_q;

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_pc_q[i]   <= ADDR_W'(ZERO_WORD);
                mem_inst_q[i] <= INST_W'(ZERO_WORD);
            end
            wr_q        <= '0;
            rd_q        <= '0;
            cnt_q       <= '0;
            hold_pc_q   <= ADDR_W'(ZERO_WORD);
            hold_inst_q <= INST_W'(ZERO_WORD);
        end else begin
            if (cnt_q != '0) begin
                hold_pc_q   <= mem_pc_q[rd_q];
                hold_inst_q <= mem_inst_q[rd_q];
            end
            if (clr_i) begin
                wr_q  <= '0;
                rd_q  <= '0;
                cnt_q <= '0;
            end else begin
                if (push_i) begin
                    mem_pc_q[wr_q]   <= push_pc_i;
                    mem_inst_q[wr_q] <= push_inst_i;
                    wr_q             <= wr_q + PTR_W'(1);
                end
                if (pop_i) begin
                    rd_q <= rd_q + PTR_W'(1);
                end
                cnt_q <= cnt_q + CNT_W'(push_i) - CNT_W'(pop_i);
            end
        end
    end

    assign count_o      = cnt_q;
    assign head_valid_o = (cnt_q != '0);
    assign head_pc_o    = head_valid_o ? mem_pc_q[rd_q]   : hold_pc_q;
    assign head_inst_o  = head_valid_o ? mem_inst_q[rd_q] : hold_inst_q;

endmodule

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction fetch: PC, ROM request and decode handshake
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   ce, addr            ROM chip enable and word address (current PC)
//   inst                combinational ROM read data for addr
//   br_flag, br_target  branch/jump redirect
//   flush, new_pc       exception/control flush; wins over br_flag
//   if_valid, if_inst,  head of the prefetch queue towards decode
//   if_pc
//   id_ready            decode takes the head this cycle
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int                ADDR_W   = INST_ADDR_W,
    parameter int                INST_W   = INST_BUS_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                DEPTH    = FETCH_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    output logic              ce,
    output logic [ADDR_W-1:0] addr,
    input  logic [INST_W-1:0] inst,
    input  logic              br_flag,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              flush,
    input  logic [ADDR_W-1:0] new_pc,
    output logic              if_valid,
    output logic [INST_W-1:0] if_inst,
    output logic [ADDR_W-1:0] if_pc,
    input  logic              id_ready
);

    localparam int               CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              run_q;
    logic [CNT_W-1:0]  count;
    logic              pop, room, fetch, redirect;
    logic [ADDR_W-1:0] redir_pc;

    assign pop      = if_valid & id_ready;
    // A slot frees up this cycle if decode takes the head, so a full queue
    // can still accept the word being fetched now.
    assign room     = (count < FULL) | pop;
    // No fetch in a redirect cycle: the word at the old PC is on the wrong path.
    assign fetch    = run_q & room & ~flush & ~br_flag;
    assign ce       = fetch ? CHIP_ENABLE : CHIP_DISABLE;
    assign addr     = pc_q;

    assign redirect = flush | br_flag;
    assign redir_pc = (flush ? new_pc : br_target) & ~ADDR_W'(~INST_ALIGN_MASK);

    always_comb begin
        pc_d = pc_q;
        if (redirect) begin
            pc_d = redir_pc;
        end else if (fetch) begin
            pc_d = pc_q + ADDR_W'(4);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            pc_q  <= RESET_PC;
            run_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            run_q <= 1'b1;
        end
    end

    fetch_fifo #(
        .ADDR_W (ADDR_W),
        .INST_W (INST_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .clr_i        (redirect),
        .push_i       (fetch),
        .push_pc_i    (pc_q),
        .push_inst_i  (inst),
        .pop_i        (pop),
        .count_o      (count),
        .head_valid_o (if_valid),
        .head_pc_o    (if_pc),
        .head_inst_o  (if_inst)
    );

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - directed table-driven bench for inst_fetch
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce;
    logic [31:0] addr;
    logic [31:0] inst;
    logic        br_flag;
    logic [31:0] br_target;
    logic        flush;
    logic [31:0] new_pc;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        id_ready;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // ROM word i lives at byte address 4*i.
    assign inst = 32'h1000_0000 + (addr >> 2);

    inst_fetch dut (
        .clk       (clk),
        .rst       (rst),
        .ce        (ce),
        .addr      (addr),
        .inst      (inst),
        .br_flag   (br_flag),
        .br_target (br_target),
        .flush     (flush),
        .new_pc    (new_pc),
        .if_valid  (if_valid),
        .if_inst   (if_inst),
        .if_pc     (if_pc),
        .id_ready  (id_ready)
    );

    typedef struct {
        logic        ir;
        logic        br;
        logic        fl;
        logic [31:0] brt;
        logic [31:0] npc;
        logic        ce;
        logic [31:0] addr;
        logic        v;
        logic [31:0] pc;
        logic [31:0] inst;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic e_ce, input logic [31:0] e_addr,
                            input logic e_v, input logic [31:0] e_pc, input logic [31:0] e_inst);
        chk({tag, " ce"},       32'(ce),       32'(e_ce));
        chk({tag, " addr"},     addr,          e_addr);
        chk({tag, " if_valid"}, 32'(if_valid), 32'(e_v));
        chk({tag, " if_pc"},    if_pc,         e_pc);
        chk({tag, " if_inst"},  if_inst,       e_inst);
    endtask

    task automatic add(input logic ir, input logic br, input logic [31:0] brt,
                       input logic fl, input logic [31:0] npc,
                       input logic e_ce, input logic [31:0] e_addr, input logic e_v,
                       input logic [31:0] e_pc, input logic [31:0] e_inst);
        vq.push_back('{ir, br, fl, brt, npc, e_ce, e_addr, e_v, e_pc, e_inst});
    endtask

    initial begin
        rst       = 1'b0;
        br_flag   = 1'b0;
        br_target = '0;
        flush     = 1'b0;
        new_pc    = '0;
        id_ready  = 1'b1;

        //   ir br  brt           fl npc            ce addr           v  pc             inst
        add(1, 0, 32'h0,         0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0);        // c0 run=0
        add(1, 0, 32'h0,         0, 32'h0,        1, 32'h0,        0, 32'h0,        32'h0);        // c1 first fetch
        add(1, 0, 32'h0,         0, 32'h0,        1, 32'h4,        1, 32'h0,        32'h1000_0000);
        add(1, 0, 32'h0,         0, 32'h0,        1, 32'h8,        1, 32'h4,        32'h1000_0001);
        add(0, 0, 32'h0,         0, 32'h0,        1, 32'hC,        1, 32'h8,        32'h1000_0002); // stall begins
        for (int i = 0; i < 4; i++)
            add(0, 0, 32'h0,     0, 32'h0,        0, 32'h10,       1, 32'h8,        32'h1000_0002); // full, pc holds
        add(1, 0, 32'h0,         0, 32'h0,        1, 32'h10,       1, 32'h8,        32'h1000_0002); // push+pop while full
        add(1, 0, 32'h0,         0, 32'h0,        1, 32'h14,       1, 32'hC,        32'h1000_0003);
        add(0, 0, 32'h0,         0, 32'h0,        0, 32'h18,       1, 32'h10,       32'h1000_0004); // full again
        add(1, 1, 32'h103,       0, 32'h0,        0, 32'h18,       1, 32'h10,       32'h1000_0004); // branch
        add(1, 0, 32'h0,         0, 32'h0,        1, 32'h100,      0, 32'h10,       32'h1000_0004); // empty, head held
        add(1, 0, 32'h0,         0, 32'h0,        1, 32'h104,      1, 32'h100,      32'h1000_0040);
        add(1, 1, 32'h40,        1, 32'h380,      0, 32'h108,      1, 32'h104,      32'h1000_0041); // flush beats branch
        add(1, 0, 32'h0,         0, 32'h0,        1, 32'h380,      0, 32'h104,      32'h1000_0041);
        add(1, 1, 32'hFFFF_FFF8, 0, 32'h0,        0, 32'h384,      1, 32'h380,      32'h1000_00E0); // branch to wrap
        add(1, 0, 32'h0,         0, 32'h0,        1, 32'hFFFF_FFF8, 0, 32'h380,     32'h1000_00E0);
        add(1, 0, 32'h0,         0, 32'h0,        1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFF8, 32'h4FFF_FFFE);
        add(1, 0, 32'h0,         0, 32'h0,        1, 32'h0,        1, 32'hFFFF_FFFC, 32'h4FFF_FFFF);
        add(1, 0, 32'h0,         0, 32'h0,        1, 32'h4,        1, 32'h0,        32'h1000_0000);
        add(0, 0, 32'h0,         0, 32'h0,        1, 32'h8,        1, 32'h4,        32'h1000_0001);
        add(0, 0, 32'h0,         0, 32'h0,        0, 32'hC,        1, 32'h4,        32'h1000_0001); // full

        repeat (3) @(posedge clk);
        #1;
        chk_outs("reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        rst = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            id_ready  = vq[i].ir;
            br_flag   = vq[i].br;
            br_target = vq[i].brt;
            flush     = vq[i].fl;
            new_pc    = vq[i].npc;
            #1;
            chk_outs($sformatf("c%0d", i), vq[i].ce, vq[i].addr, vq[i].v, vq[i].pc, vq[i].inst);
            @(posedge clk);
            #1;
        end

        // Reset while the queue is full: outputs return to reset values at once.
        id_ready  = 1'b0;
        br_flag   = 1'b0;
        flush     = 1'b0;
        #1;
        chk("prereset if_valid", 32'(if_valid), 32'd1);
        rst = 1'b0;
        #1;
        chk_outs("midreset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        rst      = 1'b1;
        id_ready = 1'b1;
        #1;
        chk_outs("restart0", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        chk_outs("restart1", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        chk_outs("restart2", 1'b1, 32'h4, 1'b1, 32'h0, 32'h1000_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
